// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and constants for the countdown controller.
//   state_e    - FSM encoding, also driven onto fsm_state
//   CUR_*      - one-hot cursor positions
//   *_MAX      - per-digit BCD upper limits (minute-tens limit is a top parameter)
//   BTN_*      - bit positions of the buttons in the press vector
//   bcd_dec    - one-second BCD decrement with borrow
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ALARM = 2'b11
  } state_e;

  // digit 0 = sec_ones ... digit 3 = min_tens
  typedef logic [3:0][3:0] time_t;

  localparam logic [3:0] CUR_SEC_ONES = 4'b0001;
  localparam logic [3:0] CUR_SEC_TENS = 4'b0010;
  localparam logic [3:0] CUR_MIN_ONES = 4'b0100;
  localparam logic [3:0] CUR_MIN_TENS = 4'b1000;

  localparam logic [3:0] SEC_ONES_MAX     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX     = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX     = 4'd9;
  localparam int         MIN_TENS_MAX_DEF = 5;

  localparam int BTN_W     = 5;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_START = 4;

  function automatic logic [1:0] cursor_idx(input logic [3:0] cur);
    logic [1:0] idx;
    case (cur)
      CUR_SEC_TENS: idx = 2'd1;
      CUR_MIN_ONES: idx = 2'd2;
      CUR_MIN_TENS: idx = 2'd3;
      default:      idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] digit_max(input logic [1:0] idx,
                                           input logic [3:0] min_tens_max);
    logic [3:0] lim;
    case (idx)
      2'd0:    lim = SEC_ONES_MAX;
      2'd1:    lim = SEC_TENS_MAX;
      2'd2:    lim = MIN_ONES_MAX;
      default: lim = min_tens_max;
    endcase
    return lim;
  endfunction

  // Caller guarantees t is nonzero, so min_tens never underflows.
  function automatic time_t bcd_dec(input time_t t);
    time_t r;
    r = t;
    if (t[0] != 4'd0) begin
      r[0] = t[0] - 4'd1;
    end else begin
      r[0] = SEC_ONES_MAX;
      if (t[1] != 4'd0) begin
        r[1] = t[1] - 4'd1;
      end else begin
        r[1] = SEC_TENS_MAX;
        if (t[2] != 4'd0) begin
          r[2] = t[2] - 4'd1;
        end else begin
          r[2] = MIN_ONES_MAX;
          r[3] = t[3] - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_ctrl_btn_edge.sv
// btn_edge: registers the button vector and flags rising edges.
//   clk, rst_n - clock and async active-low reset
//   btn_i      - debounced level buttons
//   press_o    - high for the cycle in which a button is newly high
// History resets to all ones so a button held through reset is not a press.
module btn_edge
  import countdown_pkg::*;
#(
  parameter int W = BTN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] press_o
);

  logic [W-1:0] btn_q;
  logic [W-1:0] btn_d;

  always_comb begin
    btn_d = btn_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= '1;
    end else begin
      btn_q <= btn_d;
    end
  end

  assign press_o = btn_i & ~btn_q;

endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: MM:SS countdown timer with edit, pause and alarm.
//   clk, rst_n                   - clock, async active-low reset
//   tick                         - one-cycle 1 Hz enable
//   up/down/left/right/start     - debounced level buttons
//   modify                       - edit enable while idle
//   min_tens..sec_ones           - BCD time
//   cursor                       - one-hot edit position
//   fsm_state                    - current state encoding
//   done                         - pulse in the cycle the last second expires
//   alarm                        - high while alarming
//
// state  | meaning
// IDLE   | editable time, waiting for start
// RUN    | counting down one second per tick
// PAUSE  | frozen; start resumes, down reloads preset
// ALARM  | time expired; leaves on ALARM_SEC ticks or any press
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int ALARM_SEC    = 5,
  parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  input  logic       modify,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cursor,
  output logic [1:0] fsm_state,
  output logic       done,
  output logic       alarm
);

  localparam logic [3:0] MT_MAX     = 4'(MIN_TENS_MAX);
  localparam logic [7:0] ALARM_LOAD = 8'(ALARM_SEC);

  state_e     state_q, state_d;
  time_t      digits_q, digits_d;
  time_t      preset_q, preset_d;
  logic [3:0] cursor_q, cursor_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;

  logic [BTN_W-1:0] press;
  logic [1:0]       sel;
  logic [3:0]       lim;
  logic             time_zero;
  logic             last_sec;
  logic             p_up, p_down, p_left, p_right, p_start;

  btn_edge #(.W(BTN_W)) u_btn_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   ({start, right, left, down, up}),
    .press_o (press)
  );

  assign p_up      = press[BTN_UP];
  assign p_down    = press[BTN_DOWN];
  assign p_left    = press[BTN_LEFT];
  assign p_right   = press[BTN_RIGHT];
  assign p_start   = press[BTN_START];
  assign time_zero = (digits_q == '0);
  assign last_sec  = (digits_q == 16'h0001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      digits_q    <= '0;
      preset_q    <= '0;
      cursor_q    <= CUR_SEC_ONES;
      alarm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      preset_q    <= preset_d;
      cursor_q    <= cursor_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    preset_d    = preset_q;
    cursor_d    = cursor_q;
    alarm_cnt_d = alarm_cnt_q;
    done        = 1'b0;
    sel         = cursor_idx(cursor_q);
    lim         = digit_max(sel, MT_MAX);

    case (state_q)
      ST_IDLE: begin
        // start takes the whole cycle; edits in the same cycle are dropped
        if (p_start) begin
          if (!time_zero) begin
            preset_d = digits_q;
            state_d  = ST_RUN;
          end
        end else if (modify) begin
          if (p_up && !p_down) begin
            digits_d[sel] = (digits_q[sel] >= lim) ? 4'd0 : digits_q[sel] + 4'd1;
          end else if (p_down && !p_up) begin
            digits_d[sel] = (digits_q[sel] == 4'd0) ? lim : digits_q[sel] - 4'd1;
          end
          if (p_left && !p_right) begin
            cursor_d = {cursor_q[2:0], cursor_q[3]};
          end else if (p_right && !p_left) begin
            cursor_d = {cursor_q[0], cursor_q[3:1]};
          end
        end
      end

      ST_RUN: begin
        if (tick) begin
          digits_d = bcd_dec(digits_q);
        end
        // expiry beats a same-cycle pause request
        if (tick && last_sec) begin
          done        = 1'b1;
          state_d     = ST_ALARM;
          alarm_cnt_d = ALARM_LOAD;
        end else if (p_start) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (p_start) begin
          state_d = ST_RUN;
        end else if (p_down) begin
          digits_d = preset_q;
          state_d  = ST_IDLE;
        end
      end

      ST_ALARM: begin
        if ((|press) || (tick && alarm_cnt_q <= 8'd1)) begin
          digits_d    = preset_q;
          state_d     = ST_IDLE;
          alarm_cnt_d = '0;
        end else if (tick) begin
          alarm_cnt_d = alarm_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign min_tens  = digits_q[3];
  assign min_ones  = digits_q[2];
  assign sec_tens  = digits_q[1];
  assign sec_ones  = digits_q[0];
  assign cursor    = cursor_q;
  assign fsm_state = state_q;
  assign alarm     = (state_q == ST_ALARM);

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

  localparam int ALARM_SEC = 5;
  localparam int MT_MAX    = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, up, down, left, right, start, modify;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, cursor;
  logic [1:0] fsm_state;
  logic       done, alarm;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  // reference model: time kept as total seconds
  int         m_state;   // 0 idle, 1 run, 2 pause, 3 alarm
  int         m_t;
  int         m_preset;
  int         m_cur;     // 0 sec_ones .. 3 min_tens
  int         m_acnt;    // ticks seen while alarming
  logic [4:0] m_prev;

  countdown_ctrl #(.ALARM_SEC(ALARM_SEC), .MIN_TENS_MAX(MT_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .start     (start),
    .modify    (modify),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .cursor    (cursor),
    .fsm_state (fsm_state),
    .done      (done),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_LT = 5'b00100,
                         B_RT = 5'b01000, B_ST = 5'b10000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int t);
    int v;
    v = ((t / 600) << 12) | (((t / 60) % 10) << 8) | (((t % 60) / 10) << 4) | (t % 10);
    return 16'(v);
  endfunction

  function automatic logic [15:0] dut_time();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic model_reset();
    m_state = 0; m_t = 0; m_preset = 0; m_cur = 0; m_acnt = 0; m_prev = 5'h1f;
  endtask

  task automatic model_step(input logic [4:0] b, input logic md, input logic tk);
    logic [4:0] p;
    int d[4];
    int lim[4];
    p = b & ~m_prev;
    m_prev = b;
    lim[0] = 9; lim[1] = 5; lim[2] = 9; lim[3] = MT_MAX;
    case (m_state)
      0: begin
        if (p[4]) begin
          if (m_t != 0) begin m_preset = m_t; m_state = 1; end
        end else if (md) begin
          d[0] = m_t % 10; d[1] = (m_t % 60) / 10; d[2] = (m_t / 60) % 10; d[3] = m_t / 600;
          if (p[0] && !p[1]) d[m_cur] = (d[m_cur] == lim[m_cur]) ? 0 : d[m_cur] + 1;
          else if (p[1] && !p[0]) d[m_cur] = (d[m_cur] == 0) ? lim[m_cur] : d[m_cur] - 1;
          m_t = d[3] * 600 + d[2] * 60 + d[1] * 10 + d[0];
          if (p[2] && !p[3]) m_cur = (m_cur + 1) % 4;
          else if (p[3] && !p[2]) m_cur = (m_cur + 3) % 4;
        end
      end
      1: begin
        if (tk && m_t == 1) begin
          m_t = 0; m_state = 3; m_acnt = 0;
        end else begin
          if (tk) m_t--;
          if (p[4]) m_state = 2;
        end
      end
      2: begin
        if (p[4]) m_state = 1;
        else if (p[1]) begin m_t = m_preset; m_state = 0; end
      end
      default: begin
        if (p != 0) begin
          m_t = m_preset; m_state = 0;
        end else if (tk) begin
          m_acnt++;
          if (m_acnt >= ALARM_SEC) begin m_t = m_preset; m_state = 0; end
        end
      end
    endcase
  endtask

  // one clock: drive, compare pre-edge outputs with model, advance model
  task automatic cyc(input logic [4:0] b, input logic md, input logic tk);
    up = b[0]; down = b[1]; left = b[2]; right = b[3]; start = b[4];
    modify = md; tick = tk;
    @(negedge clk);
    chk("time", 32'(dut_time()), 32'(to_bcd(m_t)));
    chk("cursor", 32'(cursor), 32'(1 << m_cur));
    chk("state", 32'(fsm_state), 32'(m_state));
    chk("done", 32'(done), 32'((m_state == 1 && tk && m_t == 1) ? 1 : 0));
    chk("alarm", 32'(alarm), 32'((m_state == 3) ? 1 : 0));
    if (done) done_cnt++;
    @(posedge clk);
    model_step(b, md, tk);
    #1;
  endtask

  task automatic press(input logic [4:0] b, input logic md);
    cyc(b, md, 1'b0);
    cyc(5'b0, md, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(5'b0, 1'b0, 1'b1);
      cyc(5'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset(input logic [4:0] held);
    up = held[0]; down = held[1]; left = held[2]; right = held[3]; start = held[4];
    modify = 1'b0; tick = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(held, 1'b0, 1'b0);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_time"}, 32'(dut_time()), 32'h0);
    chk({tag, "_cursor"}, 32'(cursor), 32'h1);
    chk({tag, "_state"}, 32'(fsm_state), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_alarm"}, 32'(alarm), 32'h0);
  endtask

  initial begin
    logic [4:0] rb;
    logic       rm;
    int         dc;

    // reset with up held: no press may appear on release
    rst_n = 1'b0;
    up = 1'b1; down = 1'b0; left = 1'b0; right = 1'b0; start = 1'b0;
    modify = 1'b1; tick = 1'b0;
    #12;
    check_reset_vals("rst");
    do_reset(B_UP);
    cyc(B_UP, 1'b1, 1'b0);
    cyc(5'b0, 1'b1, 1'b0);
    chk("held_through_reset", 32'(dut_time()), 32'h0);

    // start at 00:00 stays idle
    press(B_ST, 1'b0);
    chk("start_zero", 32'(fsm_state), 32'h0);

    // edit: up x3, left, up x2 -> 00:23, cursor sec_tens
    repeat (3) press(B_UP, 1'b1);
    press(B_LT, 1'b1);
    repeat (2) press(B_UP, 1'b1);
    chk("edit_time", 32'(dut_time()), 32'h0023);
    chk("edit_cursor", 32'(cursor), 32'h2);

    // digit wrap and ignored combos
    press(B_RT, 1'b1);
    repeat (3) press(B_DN, 1'b1);
    press(B_DN, 1'b1);
    chk("down_wrap", 32'(sec_ones), 32'd9);
    repeat (3) press(B_LT, 1'b1);
    chk("cursor_msb", 32'(cursor), 32'h8);
    repeat (5) press(B_UP, 1'b1);
    chk("min_tens_max", 32'(dut_time()), 32'h5029);
    press(B_UP, 1'b1);
    chk("up_wrap", 32'(dut_time()), 32'h0029);
    press(B_UP | B_DN, 1'b1);
    chk("up_down_ignored", 32'(dut_time()), 32'h0029);
    press(B_LT | B_RT, 1'b1);
    chk("left_right_ignored", 32'(cursor), 32'h8);
    press(B_LT, 1'b1);
    chk("cursor_wrap_left", 32'(cursor), 32'h1);
    press(B_RT, 1'b1);
    chk("cursor_wrap_right", 32'(cursor), 32'h8);
    press(B_UP, 1'b0);
    chk("modify_off", 32'(dut_time()), 32'h0029);

    // 01:00 run to alarm
    do_reset(5'b0);
    repeat (2) press(B_LT, 1'b1);
    press(B_UP, 1'b1);
    press(B_ST, 1'b0);
    chk("run_state", 32'(fsm_state), 32'h1);
    ticks(1);
    chk("first_tick", 32'(dut_time()), 32'h0059);
    dc = done_cnt;
    ticks(59);
    chk("done_once", 32'(done_cnt - dc), 32'd1);
    chk("alarm_state", 32'(fsm_state), 32'h3);
    chk("alarm_out", 32'(alarm), 32'h1);
    ticks(4);
    chk("alarm_hold", 32'(alarm), 32'h1);
    ticks(1);
    chk("alarm_drop", 32'(alarm), 32'h0);
    chk("alarm_reload", 32'(dut_time()), 32'h0100);
    chk("alarm_idle", 32'(fsm_state), 32'h0);
    press(B_ST, 1'b0);
    ticks(60);
    ticks(2);
    cyc(B_LT, 1'b0, 1'b0);
    chk("alarm_press_exit", 32'(fsm_state), 32'h0);
    cyc(5'b0, 1'b0, 1'b0);

    // pause at 00:05 from preset 00:07
    do_reset(5'b0);
    repeat (7) press(B_UP, 1'b1);
    press(B_ST, 1'b0);
    ticks(2);
    press(B_ST, 1'b0);
    chk("pause_state", 32'(fsm_state), 32'h2);
    ticks(3);
    chk("pause_frozen", 32'(dut_time()), 32'h0005);
    press(B_ST, 1'b0);
    chk("resume", 32'(fsm_state), 32'h1);
    press(B_ST, 1'b0);
    press(B_DN, 1'b0);
    chk("pause_reload", 32'(dut_time()), 32'h0007);
    chk("pause_idle", 32'(fsm_state), 32'h0);

    // expiry beats pause
    do_reset(5'b0);
    press(B_UP, 1'b1);
    press(B_ST, 1'b0);
    dc = done_cnt;
    cyc(B_ST, 1'b0, 1'b1);
    chk("expire_done", 32'(done_cnt - dc), 32'd1);
    chk("expire_alarm", 32'(fsm_state), 32'h3);
    cyc(5'b0, 1'b0, 1'b0);

    // async reset mid-run
    do_reset(5'b0);
    repeat (3) press(B_UP, 1'b1);
    press(B_ST, 1'b0);
    ticks(1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    do_reset(5'b0);

    // randomized
    rb = 5'b0;
    rm = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 5; k++) if ($urandom_range(0, 5) == 0) rb[k] = ~rb[k];
      if ($urandom_range(0, 30) == 0) rm = ~rm;
      if ($urandom_range(0, 999) == 0) do_reset(rb);
      cyc(rb, rm, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter ALARM_SEC, default 5: number of 1 Hz ticks the alarm stays asserted.
REQ-002 Parameter MIN_TENS_MAX, default 5: upper limit of the minute-tens digit; limits are ones 9, sec-tens 5.
REQ-003 clk  in  1  system clock; one clock for the whole block.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 tick  in  1  one-cycle 1 Hz enable from the clock divider.
REQ-006 up, down, left, right, start  in  1 each  debounced level buttons, active-high.
REQ-007 modify  in  1  level; edit enable while idle.
REQ-008 min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD time to the display/datapath.
REQ-009 cursor  out  4  one-hot edit position: 0001 sec_ones, 0010 sec_tens, 0100 min_ones, 1000 min_tens.
REQ-010 fsm_state  out  2  IDLE=00, RUN=01, PAUSE=10, ALARM=11.
REQ-011 done  out  1  one-cycle pulse on reaching 00:00.
REQ-012 alarm  out  1  high while in ALARM.

Function
REQ-013 Each button SHALL be rising-edge detected; a press acts on the registers one cycle after the rising input edge; held buttons SHALL NOT repeat.
REQ-014 In IDLE with modify=1, left SHALL rotate cursor toward MSB with wrap (1000->0001); right toward LSB with wrap (0001->1000).
REQ-015 In IDLE with modify=1, up SHALL increment the selected digit, wrapping max->0; down SHALL decrement, wrapping 0->max; other digits unchanged, no carry.
REQ-016 Simultaneous up+down presses SHALL be ignored; simultaneous left+right presses SHALL be ignored.
REQ-017 In IDLE with modify=0, edit buttons SHALL be ignored.
REQ-018 start in IDLE SHALL latch the current time as preset and enter RUN when time is nonzero; at 00:00 it SHALL stay IDLE.
REQ-019 In RUN, each tick SHALL decrement MM:SS by one second in BCD with borrow (e.g. 10:00 -> 09:59).
REQ-020 The tick that produces 00:00 SHALL assert done in that cycle and enter ALARM on the next edge.
REQ-021 start in RUN SHALL enter PAUSE; a same-cycle tick is still applied.
REQ-022 If tick takes time to 00:00 while start is pressed, ALARM SHALL win over PAUSE.
REQ-023 In PAUSE, ticks SHALL be ignored; start SHALL resume RUN; down SHALL reload the preset and enter IDLE.
REQ-024 In RUN/PAUSE, up, left, right and modify SHALL be ignored.
REQ-025 In ALARM, alarm=1; after ALARM_SEC ticks, or on any button press, the block SHALL reload the preset and enter IDLE.
REQ-026 Digits SHALL always remain valid BCD within their limits.

Reset
REQ-027 On rst_n=0: all digits 0, preset 00:00, cursor 0001, fsm_state IDLE, done 0, alarm 0, alarm counter 0.
REQ-028 Edge-detector history registers SHALL reset to 1, so a button held through reset produces no press.
REQ-029 Reset asserted mid-RUN or mid-ALARM SHALL abort immediately with no done pulse.

Structure
REQ-030 Package countdown_pkg SHALL hold the state encoding, the cursor one-hot constants and the digit limit constants.
REQ-031 One sub-module btn_edge (5-bit vector register plus rising-edge detect) SHALL be instantiated once for the buttons.

Verification
REQ-032 Reset, modify=1, up x3, left, up x2 -> display 00:23, cursor 0010.
REQ-033 Sec_ones=0, down -> 9; min_tens=5, up -> 0; up+down same cycle -> no change.
REQ-034 Preset 01:00, start, 1 tick -> 00:59; 59 more ticks -> done pulse once, fsm_state 11, alarm 1.
REQ-035 ALARM with ALARM_SEC=5 -> alarm drops after 5th tick, time 01:00, IDLE; repeat with a left press after 2 ticks -> IDLE immediately.
REQ-036 RUN at 00:05, start -> PAUSE; 3 ticks -> still 00:05; down -> IDLE, preset restored.
REQ-037 RUN at 00:01, tick and start same cycle -> done, ALARM; rst_n low mid-RUN -> all outputs at reset values asynchronously.
